// File: rtl/sdp_trt_arb_pkg.sv
// Shared types and constants for the SDP truncation-output arbiter.
// Stall counter width applies whether or not SDP_TRT_OUT_ARB_PERF_EN is defined.
package sdp_trt_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_DEF_NREQ = 32'sd4;
  localparam int ARB_DEF_DW   = 32'sd32;
  localparam int STALL_CNT_W  = 32'sd32;

  function automatic int rr_next(input int ptr, input int nreq);
    rr_next = ((ptr + 32'sd1) >= nreq) ? 32'sd0 : (ptr + 32'sd1);
  endfunction

endpackage

// File: rtl/sdp_trt_rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr, wrapping to lane 0.
module sdp_trt_rr_pick
  import sdp_trt_arb_pkg::*;
#(
  parameter int NREQ = ARB_DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any_vld
);

  int idx_s;

  // Scan lanes in rotated order and keep the first requester found.
  always_comb begin
    idx_s   = 32'sd0;
    gnt_id  = {IDW{1'b0}};
    any_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = (int'(rr_ptr) + i) % NREQ;
      if (!any_vld && req[idx_s]) begin
        gnt_id  = IDW'(idx_s);
        any_vld = 1'b1;
      end else begin
        gnt_id  = gnt_id;
      end
    end
  end

  assign gnt = any_vld ? (NREQ'(1'b1) << gnt_id) : {NREQ{1'b0}};

endmodule

// File: rtl/sdp_trt_out_arb.sv
// Packet-locked round-robin arbiter feeding the single chn_trt_out channel.
// Define SDP_TRT_OUT_ARB_PERF_EN to build the output-stall counter.
module sdp_trt_out_arb
  import sdp_trt_arb_pkg::*;
#(
  parameter int NREQ = ARB_DEF_NREQ,
  parameter int DW   = ARB_DEF_DW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [NREQ-1:0]        req_vld,
  input  logic [NREQ*DW-1:0]     req_pd,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_rdy,
  output logic                   chn_trt_out_vld,
  output logic [DW-1:0]          chn_trt_out_pd,
  output logic                   chn_trt_out_last,
  output logic [IDW-1:0]         chn_trt_out_id,
  input  logic                   chn_trt_out_rdy,
  input  logic                   perf_clr,
  output logic [STALL_CNT_W-1:0] perf_stall_cnt
);

  arb_state_e      state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  lock_id_r;
  logic [NREQ-1:0] pick_gnt_s;
  logic [IDW-1:0]  pick_id_s;
  logic            pick_any_s;
  logic            can_load_s;
  logic            load_s;
  logic [IDW-1:0]  load_id_s;
  logic [DW-1:0]   load_pd_s;
  logic            load_last_s;
  logic [NREQ-1:0] rdy_s;

  assign can_load_s = ~chn_trt_out_vld | chn_trt_out_rdy;

  sdp_trt_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_vld),
    .rr_ptr  (rr_ptr_r),
    .gnt     (pick_gnt_s),
    .gnt_id  (pick_id_s),
    .any_vld (pick_any_s)
  );

  // Grant decode: a locked lane owns the channel even while it bubbles.
  always_comb begin
    rdy_s     = {NREQ{1'b0}};
    load_s    = 1'b0;
    load_id_s = {IDW{1'b0}};
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s && can_load_s) begin
          rdy_s     = pick_gnt_s;
          load_s    = 1'b1;
          load_id_s = pick_id_s;
        end else begin
          rdy_s     = {NREQ{1'b0}};
        end
      end
      ARB_LOCK: begin
        rdy_s[lock_id_r] = can_load_s;
        load_s           = can_load_s & req_vld[lock_id_r];
        load_id_s        = lock_id_r;
      end
      default: begin
        rdy_s = {NREQ{1'b0}};
      end
    endcase
  end

  assign req_rdy     = rdy_s & {NREQ{nvdla_core_rstn}};
  assign load_pd_s   = req_pd[int'(load_id_s)*DW +: DW];
  assign load_last_s = req_last[load_id_s];

  // Output stage plus packet lock / round-robin pointer.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      chn_trt_out_vld  <= 1'b0;
      chn_trt_out_pd   <= {DW{1'b0}};
      chn_trt_out_last <= 1'b0;
      chn_trt_out_id   <= {IDW{1'b0}};
      state_r          <= ARB_IDLE;
      rr_ptr_r         <= {IDW{1'b0}};
      lock_id_r        <= {IDW{1'b0}};
    end else begin
      if (load_s) begin
        chn_trt_out_vld  <= 1'b1;
        chn_trt_out_pd   <= load_pd_s;
        chn_trt_out_last <= load_last_s;
        chn_trt_out_id   <= load_id_s;
      end else if (chn_trt_out_rdy) begin
        chn_trt_out_vld  <= 1'b0;
      end
      if (load_s && load_last_s) begin
        state_r  <= ARB_IDLE;
        rr_ptr_r <= IDW'(rr_next(int'(load_id_s), NREQ));
      end else if (load_s && (state_r == ARB_IDLE)) begin
        state_r   <= ARB_LOCK;
        lock_id_r <= load_id_s;
      end
    end
  end

`ifdef SDP_TRT_OUT_ARB_PERF_EN
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  // Stall counter: clear beats increment, and the count sticks at all-ones.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (perf_clr) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (chn_trt_out_vld && !chn_trt_out_rdy && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1'b1);
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
`else
  logic perf_clr_unused;
  assign perf_clr_unused = perf_clr;
  assign perf_stall_cnt  = {STALL_CNT_W{1'b0}};
`endif

endmodule
